axil_csr_bank: RTL and testbench

Parameterised AXI4-Lite slave control/status register bank, successor to the single-width scratch-memory slave. It supports configurable data width and register count, independent AW/W acceptance, and AXI response codes. Each register is either read/write or read-only, with read-only registers sourced from hardware inputs. It sits between the AXI-Lite interconnect and datapath blocks needing CSRs.

---
 rtl/axil_pkg.sv | 19 +
 rtl/axil_csr_bank_if.sv | 33 +++
 rtl/axil_wr_collect.sv | 63 ++++++
 rtl/axil_csr_bank.sv | 179 +++++++++++++++++
 tb/tb_axil_csr_bank.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite CSR bank.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Number of byte-offset address bits below the word index.
    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_csr_bank_if.sv
// AXI4-Lite bus bundle; master drives requests, slave drives readies and responses.
interface axil_csr_bank_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_wr_collect.sv
// Collects independent AW and W beats and raises a commit strobe once both are present.
module axil_wr_collect #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic                    aw_valid,
    output logic                    aw_ready_c,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_valid,
    output logic                    w_ready_c,
    input  logic                    b_valid,
    output logic                    commit_c,
    output logic [ADDR_WIDTH-1:0]   cm_addr_c,
    output logic [DATA_WIDTH-1:0]   cm_data_c,
    output logic [DATA_WIDTH/8-1:0] cm_strb_c
);
    logic                    aw_held;
    logic                    w_held;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic                    aw_hs_c;
    logic                    w_hs_c;

    // Readies drop while a beat is parked or the response is still pending.
    assign aw_ready_c = !aw_held && !b_valid;
    assign w_ready_c  = !w_held && !b_valid;
    assign aw_hs_c    = aw_valid && aw_ready_c;
    assign w_hs_c     = w_valid && w_ready_c;
    assign commit_c   = (aw_held || aw_hs_c) && (w_held || w_hs_c);

    // A beat arriving on the commit edge bypasses its holding register.
    assign cm_addr_c = aw_held ? addr_q : aw_addr;
    assign cm_data_c = w_held  ? data_q : w_data;
    assign cm_strb_c = w_held  ? strb_q : w_strb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            if (aw_hs_c) addr_q <= aw_addr;
            if (w_hs_c) begin
                data_q <= w_data;
                strb_q <= w_strb;
            end
            if (commit_c) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs_c) aw_held <= 1'b1;
                if (w_hs_c)  w_held  <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/axil_csr_bank.sv
// AXI4-Lite CSR bank with per-register RW/RO selection.
// Optional AXIL_CSR_DECERR_EN: out-of-range indices answer SLVERR instead of aliasing.
module axil_csr_bank
    import axil_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    axil_csr_bank_if.slave                 bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int unsigned ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned SEL_W    = $clog2(NUM_REGS);
    localparam int unsigned STRB_W   = DATA_WIDTH / 8;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("axil_csr_bank: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 2 || NUM_REGS > (1 << IDX_W)) begin : g_bad_nregs
        $error("axil_csr_bank: NUM_REGS out of range for ADDR_WIDTH");
    end
`ifndef AXIL_CSR_DECERR_EN
    if ((NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_not_pow2
        $error("axil_csr_bank: NUM_REGS must be a power of two when indices alias");
    end
`endif

    // One-hot register select from a byte address; all-zero means out of range.
    function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [IDX_W-1:0] idx;
        idx    = addr[ADDR_WIDTH-1:ADDR_LSB];
        decode = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
`ifdef AXIL_CSR_DECERR_EN
            decode[i] = (idx == IDX_W'(i));
`else
            decode[i] = (idx[SEL_W-1:0] == SEL_W'(i));
`endif
        end
    endfunction

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic                  commit_c;
    logic [ADDR_WIDTH-1:0] cm_addr_c;
    logic [DATA_WIDTH-1:0] cm_data_c;
    logic [STRB_W-1:0]     cm_strb_c;
    logic [NUM_REGS-1:0]   wr_sel_c;
    resp_t                 wr_resp_c;
    logic                  aw_ready_c;
    logic                  w_ready_c;
    logic                  b_valid;
    resp_t                 b_resp;

    axil_wr_collect #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_collect (
        .clk        (clk),
        .rst_n      (rst_n),
        .aw_addr    (bus.AWADDR),
        .aw_valid   (bus.AWVALID),
        .aw_ready_c (aw_ready_c),
        .w_data     (bus.WDATA),
        .w_strb     (bus.WSTRB),
        .w_valid    (bus.WVALID),
        .w_ready_c  (w_ready_c),
        .b_valid    (b_valid),
        .commit_c   (commit_c),
        .cm_addr_c  (cm_addr_c),
        .cm_data_c  (cm_data_c),
        .cm_strb_c  (cm_strb_c)
    );

    assign wr_sel_c = decode(cm_addr_c);
`ifdef AXIL_CSR_DECERR_EN
    assign wr_resp_c = (|wr_sel_c) ? OKAY : SLVERR;
`else
    assign wr_resp_c = OKAY;
`endif

    // Register storage, write strobes and write response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs     <= '0;
            wr_pulse <= '0;
            b_valid  <= 1'b0;
            b_resp   <= OKAY;
        end else begin
            wr_pulse <= commit_c ? wr_sel_c : '0;
            if (commit_c) begin
                b_valid <= 1'b1;
                b_resp  <= wr_resp_c;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_sel_c[i] && !RO_MASK[i]) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (cm_strb_c[b]) regs[i][8*b +: 8] <= cm_data_c[8*b +: 8];
                        end
                    end
                end
            end else if (bus.BREADY) begin
                b_valid <= 1'b0;
            end
        end
    end

    assign reg_q       = regs;
    assign bus.AWREADY = aw_ready_c;
    assign bus.WREADY  = w_ready_c;
    assign bus.BVALID  = b_valid;
    assign bus.BRESP   = b_resp;

    rd_state_t             rd_state;
    rd_state_t             rd_next;
    logic                  rd_load_c;
    logic [NUM_REGS-1:0]   rd_sel_c;
    logic [DATA_WIDTH-1:0] rd_data_c;
    resp_t                 rd_resp_c;
    logic [DATA_WIDTH-1:0] r_data;
    resp_t                 r_resp;

    assign rd_sel_c = decode(bus.ARADDR);
`ifdef AXIL_CSR_DECERR_EN
    assign rd_resp_c = (|rd_sel_c) ? OKAY : SLVERR;
`else
    assign rd_resp_c = OKAY;
`endif

    // Read mux: RO registers reflect hardware inputs, RW registers their storage.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel_c[i]) rd_data_c = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= R_IDLE;
        else        rd_state <= rd_next;
    end

    always_comb begin
        rd_next   = rd_state;
        rd_load_c = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (bus.ARVALID) begin
                    rd_load_c = 1'b1;
                    rd_next   = R_DATA;
                end
            end
            R_DATA: begin
                if (bus.RREADY) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_resp <= OKAY;
        end else if (rd_load_c) begin
            r_data <= rd_data_c;
            r_resp <= rd_resp_c;
        end
    end

    assign bus.ARREADY = (rd_state == R_IDLE);
    assign bus.RVALID  = (rd_state == R_DATA);
    assign bus.RDATA   = r_data;
    assign bus.RRESP   = r_resp;
endmodule

// File: tb/tb_axil_csr_bank.sv
// Directed plus randomized bench for axil_csr_bank against an array-based register model.
module tb_axil_csr_bank;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 8;
    localparam logic [NR-1:0] RO = 8'h08;

    logic clk;
    logic rst_n;
    logic [NR*DW-1:0] reg_q_w;
    logic [NR*DW-1:0] reg_in_v;
    logic [NR-1:0]    wr_pulse_w;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [NR];

    axil_csr_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axil_csr_bank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RO_MASK    (RO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .reg_q    (reg_q_w),
        .reg_in   (reg_in_v),
        .wr_pulse (wr_pulse_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Target register for an address, or -1 when the address maps to nothing.
    function automatic int target(input logic [AW-1:0] a);
        int w;
        w = int'(a) / 4;
`ifdef AXIL_CSR_DECERR_EN
        return (w < NR) ? w : -1;
`else
        return w % NR;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        int t;
        t = target(a);
        if (t < 0) return '0;
        if (RO[t]) return reg_in_v[t*DW +: DW];
        return model[t];
    endfunction

    function automatic logic [NR*DW-1:0] exp_regq();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO[i] ? '0 : model[i];
        return v;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
        return (target(a) < 0) ? 2'b10 : 2'b00;
    endfunction

    // Entered and left at a negedge.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_stall);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc, t;
        logic [NR-1:0] exp_p;
        aw_done = 0; w_done = 0; cyc = 0;
        bus.BREADY = 1'b0;
        while (!(aw_done && w_done) && cyc < 64) begin
            bus.AWADDR  = addr;
            bus.AWVALID = !aw_done && cyc >= aw_dly;
            bus.WDATA   = data;
            bus.WSTRB   = strb;
            bus.WVALID  = !w_done && cyc >= w_dly;
            #1;
            if (w_done && !aw_done) check("wready_while_w_held", 256'(bus.WREADY), 256'(0));
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            @(posedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            @(negedge clk);
            cyc++;
        end
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        if (!(aw_done && w_done)) check("wr_accept_timeout", 256'(0), 256'(1));
        t = target(addr);
        exp_p = '0;
        if (t >= 0) begin
            exp_p[t] = 1'b1;
            if (!RO[t])
                for (int b = 0; b < 4; b++) if (strb[b]) model[t][8*b +: 8] = data[8*b +: 8];
        end
        check("bvalid_after_commit", 256'(bus.BVALID), 256'(1));
        check("bresp", 256'(bus.BRESP), 256'(exp_resp(addr)));
        check("wr_pulse", 256'(wr_pulse_w), 256'(exp_p));
        check("reg_q_after_write", reg_q_w, exp_regq());
        for (int s = 0; s < b_stall; s++) begin
            @(negedge clk);
            check("bvalid_stall", 256'(bus.BVALID), 256'(1));
            check("bresp_stall", 256'(bus.BRESP), 256'(exp_resp(addr)));
            check("wr_pulse_one_cycle", 256'(wr_pulse_w), 256'(0));
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("bvalid_cleared", 256'(bus.BVALID), 256'(0));
        check("awready_back", 256'(bus.AWREADY), 256'(1));
        check("wready_back", 256'(bus.WREADY), 256'(1));
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int stall);
        logic [DW-1:0] ed;
        logic [1:0] er;
        ed = exp_read(addr);
        er = exp_resp(addr);
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        #1;
        check("arready_idle", 256'(bus.ARREADY), 256'(1));
        @(negedge clk);
        bus.ARVALID = 1'b0;
        check("rvalid", 256'(bus.RVALID), 256'(1));
        check("rdata", 256'(bus.RDATA), 256'(ed));
        check("rresp", 256'(bus.RRESP), 256'(er));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("rvalid_stall", 256'(bus.RVALID), 256'(1));
            check("rdata_stall", 256'(bus.RDATA), 256'(ed));
            check("arready_stall", 256'(bus.ARREADY), 256'(0));
        end
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        check("rvalid_cleared", 256'(bus.RVALID), 256'(0));
        check("arready_back", 256'(bus.ARREADY), 256'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 256'(bus.AWREADY), 256'(1));
        check({tag, "_wready"}, 256'(bus.WREADY), 256'(1));
        check({tag, "_arready"}, 256'(bus.ARREADY), 256'(1));
        check({tag, "_bvalid"}, 256'(bus.BVALID), 256'(0));
        check({tag, "_rvalid"}, 256'(bus.RVALID), 256'(0));
        check({tag, "_bresp"}, 256'(bus.BRESP), 256'(0));
        check({tag, "_rresp"}, 256'(bus.RRESP), 256'(0));
        check({tag, "_rdata"}, 256'(bus.RDATA), 256'(0));
        check({tag, "_reg_q"}, reg_q_w, 256'(0));
        check({tag, "_wr_pulse"}, 256'(wr_pulse_w), 256'(0));
    endtask

    initial begin
        logic [AW-1:0] a;
        rst_n = 1'b0;
        reg_in_v = '0;
        bus.AWADDR = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0;  bus.WSTRB = '0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // AW and W together.
        axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        // W leads AW by three cycles; only byte 0 changes.
        axi_write(8'h08, 32'h11223344, 4'hF, 0, 0, 1);
        axi_write(8'h08, 32'h000000AA, 4'h1, 3, 0, 0);
        check("partial_strobe", 256'(reg_q_w[2*DW +: DW]), 256'(32'h112233AA));
        // AW leads W.
        axi_write(8'h1C, 32'h55AA55AA, 4'hA, 0, 2, 2);
        // Held read response.
        axi_read(8'h04, 4);
        // RO register: write ignored, read returns hardware value.
        reg_in_v[3*DW +: DW] = 32'h12345678;
        axi_write(8'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        axi_read(8'h0C, 0);
        // Beyond NUM_REGS: alias or SLVERR depending on build.
        axi_write(8'h40, 32'hA5A5_0001, 4'hF, 0, 0, 0);
        axi_read(8'h40, 1);
        axi_read(8'h00, 0);
        axi_read(8'h07, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR; i++) reg_in_v[i*DW +: DW] = $urandom;
            a = AW'($urandom);
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 3));
        end

        // Reset with AW held and W pending aborts the write.
        bus.AWADDR = 8'h10; bus.AWVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0;
        bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) model[i] = '0;
        check_reset_outputs("mid_reset");
        bus.WVALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        bus.WVALID = 1'b0;
        repeat (3) @(negedge clk);
        check("w_alone_no_bvalid", 256'(bus.BVALID), 256'(0));
        check("w_alone_no_pulse", 256'(wr_pulse_w), 256'(0));
        check("w_alone_no_change", reg_q_w, 256'(0));
        check("w_alone_wready_low", 256'(bus.WREADY), 256'(0));
        bus.AWADDR = 8'h14; bus.AWVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0;
        model[5] = 32'hCAFEF00D;
        check("late_aw_bvalid", 256'(bus.BVALID), 256'(1));
        check("late_aw_pulse", 256'(wr_pulse_w), 256'(8'h20));
        check("late_aw_reg_q", reg_q_w, exp_regq());
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("late_aw_bvalid_clr", 256'(bus.BVALID), 256'(0));
        axi_read(8'h14, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
